// File: rtl/sppm_frame_ctrl_pkg.sv
// Shared types and helpers for the SPPM frame sequencer.
// State encoding, no-hit sentinel and saturating increment.
package sppm_pkg;

    localparam int unsigned TMR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN
    } state_e;

    function automatic logic [31:0] all_ones(input int unsigned w);
        logic [31:0] r;
        if (w >= 32) begin
            r = 32'hFFFF_FFFF;
        end else begin
            r = (32'd1 << w) - 32'd1;
        end
        return r;
    endfunction

    function automatic logic [31:0] POS_NONE(input int unsigned w);
        return all_ones(w);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input int unsigned w);
        logic [31:0] top;
        top = all_ones(w);
        return (v >= top) ? top : v + 32'd1;
    endfunction

endpackage

// File: rtl/sppm_frame_ctrl_if.sv
// Result handshake bundle between the frame sequencer and its consumer.
// Master drives the result, slave returns ready.
interface sppm_res_if #(
    parameter int POS_W = 7,
    parameter int CNT_W = 8
);
    logic             res_valid;
    logic             res_ready;
    logic [POS_W-1:0] res_pos;
    logic [CNT_W-1:0] res_hits;

    modport master (
        output res_valid,
        output res_pos,
        output res_hits,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_pos,
        input  res_hits,
        output res_ready
    );
endinterface

// File: rtl/sppm_frame_ctrl_timer.sv
// Modulo-LEN frame position counter.
// clr holds the count at zero; wrap_o flags the last position.
module sppm_frame_timer #(
    parameter int unsigned LEN = 128,
    parameter int unsigned W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = (cnt_q == W'(LEN - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || wrap_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sppm_frame_ctrl.sv
// SPPM frame sequencer: issues syn strobes, reduces each readout
// window to first-hit slot and hit count, and hands it downstream.
module sppm_frame_ctrl
    import sppm_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 128,
    parameter int unsigned NBINS     = 101,
    parameter int unsigned POS_W     = 7,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             syn_o,
    input  logic             det_i,
    sppm_res_if.master       res,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam logic [TMR_W-1:0] T_FIRST = TMR_W'(1);
    localparam logic [TMR_W-1:0] T_LAST  = TMR_W'(NBINS);
    localparam logic [TMR_W-1:0] T_PUSH  = TMR_W'(NBINS + 1);
    localparam logic [POS_W-1:0] PNONE   = POS_W'(POS_NONE(POS_W));

    state_e             state_q, state_d;
    logic               syn_q, syn_d;
    logic [TMR_W-1:0]   tmr;
    logic               wrap;
    logic               tmr_clr;

    logic [POS_W-1:0]   pos_acc_q, pos_acc_d;
    logic [CNT_W-1:0]   hit_acc_q, hit_acc_d;

    logic               vld_q, vld_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic               rd_phase;
    logic               win;
    logic               push;

    sppm_frame_timer #(
        .LEN (FRAME_LEN),
        .W   (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .cnt_o  (tmr),
        .wrap_o (wrap)
    );

    // Readout of the previous frame overlaps capture in RUN and DRAIN.
    assign rd_phase = (state_q == RUN) || (state_q == DRAIN);
    assign win      = rd_phase && (tmr >= T_FIRST) && (tmr <= T_LAST);
    assign push     = rd_phase && (tmr == T_PUSH);

    always_comb begin
        state_d = state_q;
        syn_d   = 1'b0;
        tmr_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (en) begin
                    state_d = PRIME;
                    syn_d   = 1'b1;
                end
            end
            PRIME: begin
                if (wrap) begin
                    if (en) begin
                        state_d = RUN;
                        syn_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                if (wrap) begin
                    if (en) begin
                        syn_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tmr == T_PUSH) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pos_acc_d = pos_acc_q;
        hit_acc_d = hit_acc_q;
        if (rd_phase && (tmr == T_FIRST)) begin
            pos_acc_d = PNONE;
            hit_acc_d = '0;
        end
        if (win && det_i) begin
            if (pos_acc_d == PNONE) begin
                pos_acc_d = POS_W'(tmr - T_FIRST);
            end
            hit_acc_d = CNT_W'(sat_inc(32'(hit_acc_d), CNT_W));
        end
    end

    // A pending result is only replaced when the consumer takes it.
    always_comb begin
        vld_d  = vld_q;
        pos_d  = pos_q;
        hits_d = hits_q;
        fcnt_d = fcnt_q;
        drop_d = drop_q;
        if (push) begin
            if (!vld_q || res.res_ready) begin
                vld_d  = 1'b1;
                pos_d  = pos_acc_q;
                hits_d = hit_acc_q;
                fcnt_d = fcnt_q + 16'd1;
            end else begin
                drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            end
        end else if (vld_q && res.res_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            syn_q     <= 1'b0;
            pos_acc_q <= PNONE;
            hit_acc_q <= '0;
            vld_q     <= 1'b0;
            pos_q     <= PNONE;
            hits_q    <= '0;
            fcnt_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            syn_q     <= syn_d;
            pos_acc_q <= pos_acc_d;
            hit_acc_q <= hit_acc_d;
            vld_q     <= vld_d;
            pos_q     <= pos_d;
            hits_q    <= hits_d;
            fcnt_q    <= fcnt_d;
            drop_q    <= drop_d;
        end
    end

    assign syn_o         = syn_q;
    assign res.res_valid = vld_q;
    assign res.res_pos   = pos_q;
    assign res.res_hits  = hits_q;
    assign frame_cnt     = fcnt_q;
    assign drop_cnt      = drop_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sppm_frame_ctrl.sv
// Self-checking bench for sppm_frame_ctrl: cycle model plus
// directed literal checks over randomized detections and backpressure.
module tb_sppm_frame_ctrl;

    localparam int FL = 128;
    localparam int NB = 101;
    localparam int PW = 7;
    localparam int CW = 8;
    localparam int K0 = 3800;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          det_i;
    logic          syn_o;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic [CW-1:0] drop_cnt;

    sppm_res_if #(.POS_W(PW), .CNT_W(CW)) rif();

    sppm_frame_ctrl #(
        .FRAME_LEN (FL),
        .NBINS     (NB),
        .POS_W     (PW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .syn_o     (syn_o),
        .det_i     (det_i),
        .res       (rif),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int k      = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)",
                     nm, act, exp, k);
        end
    endtask

    // Behavioural model: mode + frame position, results from slot array.
    int            mode;
    int            t;
    bit            slot [NB];
    bit            pushed;
    int            r_pos;
    int            r_hits;
    logic          e_syn;
    logic          e_vld;
    logic [PW-1:0] e_pos;
    logic [CW-1:0] e_hits;
    logic [15:0]   e_fcnt;
    logic [CW-1:0] e_drop;
    logic          e_busy;

    initial begin
        mode = 0;
        t    = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mode   = 0;
                t      = 0;
                e_syn  = 0;
                e_vld  = 0;
                e_pos  = '1;
                e_hits = 0;
                e_fcnt = 0;
                e_drop = 0;
            end else begin
                if (mode >= 2 && t >= 1 && t <= NB) slot[t-1] = det_i;
                pushed = (mode >= 2 && t == NB + 1);
                if (pushed) begin
                    r_pos  = (1 << PW) - 1;
                    r_hits = 0;
                    for (int i = NB - 1; i >= 0; i--)
                        if (slot[i]) r_pos = i;
                    for (int i = 0; i < NB; i++)
                        r_hits += int'(slot[i]);
                    if (r_hits > (1 << CW) - 1) r_hits = (1 << CW) - 1;
                end
                if (pushed && (!e_vld || rif.res_ready)) begin
                    e_vld  = 1;
                    e_pos  = PW'(r_pos);
                    e_hits = CW'(r_hits);
                    e_fcnt = e_fcnt + 16'd1;
                end else if (pushed) begin
                    if (e_drop != '1) e_drop = e_drop + 1'b1;
                end else if (e_vld && rif.res_ready) begin
                    e_vld = 0;
                end
                e_syn = 0;
                case (mode)
                    0: if (en) begin
                        mode  = 1;
                        t     = 0;
                        e_syn = 1;
                    end
                    1, 2: if (t == FL - 1) begin
                        t = 0;
                        if (en) begin
                            mode  = 2;
                            e_syn = 1;
                        end else begin
                            mode = (mode == 1) ? 0 : 3;
                        end
                    end else begin
                        t++;
                    end
                    default: if (t == NB + 1) begin
                        mode = 0;
                        t    = 0;
                    end else begin
                        t++;
                    end
                endcase
            end
            e_busy = (mode != 0);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("syn_o", syn_o, e_syn);
            chk("res_valid", rif.res_valid, e_vld);
            chk("res_pos", rif.res_pos, e_pos);
            chk("res_hits", rif.res_hits, e_hits);
            chk("frame_cnt", frame_cnt, e_fcnt);
            chk("drop_cnt", drop_cnt, e_drop);
            chk("busy", busy, e_busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    function automatic logic rnd(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    initial begin
        rst           = 1;
        en            = 0;
        det_i         = 0;
        rif.res_ready = 1;
        repeat (3) step();
        chk("rst_syn", syn_o, 0);
        chk("rst_valid", rif.res_valid, 0);
        chk("rst_pos", rif.res_pos, 7'h7f);
        chk("rst_hits", rif.res_hits, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_busy", busy, 0);

        rst = 0;
        en  = 1;
        k   = 0;
        while (k < 1000) begin
            rif.res_ready = !(k >= 361 && k <= 870);
            det_i = (k == 135) || (k == 136) || (k == 170) ||
                    (k == 257) || (k == 359) || (k == 396) ||
                    (k == 406) || (k >= 513 && rnd(4));
            step();
            case (k)
                1, 129, 257: chk("syn_strobe", syn_o, 1);
                128: chk("prime_no_syn", syn_o, 0);
                231: chk("prime_no_result", rif.res_valid, 0);
                232: begin
                    chk("f1_valid", rif.res_valid, 1);
                    chk("f1_pos", rif.res_pos, 5);
                    chk("f1_hits", rif.res_hits, 3);
                    chk("f1_fcnt", frame_cnt, 1);
                end
                360: begin
                    chk("nohit_valid", rif.res_valid, 1);
                    chk("nohit_pos", rif.res_pos, 127);
                    chk("nohit_hits", rif.res_hits, 0);
                    chk("nohit_fcnt", frame_cnt, 2);
                end
                488: begin
                    chk("f3_pos", rif.res_pos, 10);
                    chk("f3_hits", rif.res_hits, 2);
                    chk("f3_fcnt", frame_cnt, 3);
                end
                616: chk("drop_one", drop_cnt, 1);
                744: begin
                    chk("held_valid", rif.res_valid, 1);
                    chk("held_pos", rif.res_pos, 10);
                    chk("held_hits", rif.res_hits, 2);
                    chk("drop_two", drop_cnt, 2);
                end
                872: begin
                    chk("reload_fcnt", frame_cnt, 4);
                    chk("reload_drop", drop_cnt, 2);
                    chk("reload_valid", rif.res_valid, 1);
                end
                default: ;
            endcase
        end

        while (k < 1700) begin
            if (k >= 1449) en = 0;
            else en = (k % FL == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rif.res_ready = (k >= 1500) ? 1'b1 : !rnd(3);
            det_i = rnd(4);
            step();
            case (k)
                1409: chk("last_syn", syn_o, 1);
                1537: chk("drain_no_syn", syn_o, 0);
                1639: chk("drain_busy", busy, 1);
                1640: begin
                    chk("drain_idle", busy, 0);
                    chk("drain_valid", rif.res_valid, 1);
                end
                default: ;
            endcase
        end

        while (k < 3400) begin
            if (rnd(150)) en = !en;
            rif.res_ready = !rnd(4);
            det_i = rnd(5);
            step();
        end

        while (k < K0) begin
            en = 0;
            rif.res_ready = 1;
            det_i = rnd(5);
            step();
        end
        chk("idle_before_rst", busy, 0);

        while (k < K0 + 500) begin
            en  = 1;
            rst = (k == K0 + 180);
            rif.res_ready = 1;
            det_i = (k == K0 + 133) || (k == K0 + 137) || (k == K0 + 180);
            step();
            if (k == K0 + 1) chk("restart_syn", syn_o, 1);
            if (k == K0 + 181) begin
                chk("mrst_syn", syn_o, 0);
                chk("mrst_valid", rif.res_valid, 0);
                chk("mrst_pos", rif.res_pos, 7'h7f);
                chk("mrst_hits", rif.res_hits, 0);
                chk("mrst_fcnt", frame_cnt, 0);
                chk("mrst_drop", drop_cnt, 0);
                chk("mrst_busy", busy, 0);
            end
            if (k == K0 + 182) begin
                chk("reprime_syn", syn_o, 1);
                chk("reprime_busy", busy, 1);
            end
            if (k == K0 + 412) chk("reprime_no_early", rif.res_valid, 0);
            if (k == K0 + 413) begin
                chk("reprime_valid", rif.res_valid, 1);
                chk("reprime_pos", rif.res_pos, 127);
                chk("reprime_fcnt", frame_cnt, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
